// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace monitor: channel indices, drop-counter
// width and entry-layout helpers.
package cpu_trace_pkg;

  localparam int CH_RF  = 0;
  localparam int CH_DM  = 1;
  localparam int DROP_W = 16;

  // Channel-index field is never narrower than one bit, even for a single channel.
  function automatic int calc_ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Entry layout is {cycle, ch, addr, data}, MSB to LSB.
  function automatic int calc_entry_w(input int cyc_w, input int ch_w,
                                      input int addr_w, input int data_w);
    return cyc_w + ch_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo_mw.sv
// Multi-write, single-read trace FIFO. Up to CH entries are written per clock
// at consecutive slots; the caller supplies the count and guarantees it fits.
// Pointers carry one extra wrap bit so level = wr_ptr - rd_ptr directly.
module trace_fifo_mw #(
  parameter int EW    = 57,
  parameter int CH    = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CNT_W-1:0]           wr_cnt_i,
  input  logic [CH*EW-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [EW-1:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [$clog2(DEPTH):0]     space_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          pop;

  // Occupancy, free space and pointer advance from the registered pointers.
  always_comb begin
    level_o    = wr_ptr_q - rd_ptr_q;
    space_o    = (AW+1)'(DEPTH) - level_o;
    rd_valid_o = (level_o != '0);
    pop        = rd_en_i && rd_valid_o;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_cnt_i);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
  end

  // Show-ahead head entry.
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is not reset; slot k of the write bundle lands at wr_ptr+k.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CH; k++) begin
      if (k < int'(wr_cnt_i)) begin
        mem_q[wr_ptr_q[AW-1:0] + AW'(k)] <= wr_data_i[k*EW +: EW];
      end
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Writeback/store trace monitor. Timestamps strobed channel events, pushes them
// all-or-nothing into trace_fifo_mw, counts drops and raises a sticky done flag
// on run length or idle timeout.
// Build option: define TRACE_R0_FILTER_EN to discard channel-0 writes to
// address 0 (register $zero) before they are counted.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int CH         = 2,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 100,
  parameter int IDLE_LIMIT = 8
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [CH-1:0]                                     ev_we_i,
  input  logic [CH*ADDR_W-1:0]                              ev_addr_i,
  input  logic [CH*DATA_W-1:0]                              ev_data_i,
  input  logic                                              rd_en_i,
  output logic                                              rd_valid_o,
  output logic [CYC_W+calc_ch_w(CH)+ADDR_W+DATA_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0]                            level_o,
  output logic [DROP_W-1:0]                                 drop_cnt_o,
  output logic [CYC_W-1:0]                                  cycle_o,
  output logic                                              done_o
);

  localparam int CH_W    = calc_ch_w(CH);
  localparam int ENTRY_W = calc_entry_w(CYC_W, CH_W, ADDR_W, DATA_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int CNT_W   = $clog2(CH + 1);

  logic [CYC_W-1:0]     cycle_q, cycle_d;
  logic [CYC_W-1:0]     idle_q, idle_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 done_q, done_d;

  logic [CH-1:0]        ev_valid;
  logic [CNT_W-1:0]     ev_cnt;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CH*ENTRY_W-1:0] wr_data;
  logic [LVL_W-1:0]     space;
  logic                 accept;
  logic [DROP_W:0]      drop_sum;

  // Qualify strobes: optional $zero filter, and no capture once stopped.
  always_comb begin
    ev_valid = ev_we_i;
`ifdef TRACE_R0_FILTER_EN
    if (ev_addr_i[CH_RF*ADDR_W +: ADDR_W] == '0) ev_valid[CH_RF] = 1'b0;
`endif
    if (done_q) ev_valid = '0;
  end

  // Pack valid events into consecutive slots in ascending channel order.
  always_comb begin
    int slot;
    slot    = 0;
    wr_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (ev_valid[k]) begin
        wr_data[slot*ENTRY_W +: ENTRY_W] = {cycle_q, CH_W'(k),
                                            ev_addr_i[k*ADDR_W +: ADDR_W],
                                            ev_data_i[k*DATA_W +: DATA_W]};
        slot = slot + 1;
      end
    end
    ev_cnt = CNT_W'(slot);
  end

  // Space is judged before this cycle's pop, so a full FIFO drops even when popped.
  always_comb begin
    accept   = (LVL_W'(ev_cnt) <= space);
    wr_cnt   = accept ? ev_cnt : '0;
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(ev_cnt);
    drop_d   = drop_q;
    if (!accept) drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    cycle_d  = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
    if (ev_cnt != '0)   idle_d = '0;
    else if (&idle_q)   idle_d = idle_q;
    else                idle_d = idle_q + 1'b1;
    done_d   = done_q
             || (cycle_q == CYC_W'(MAX_CYCLES - 1))
             || ((ev_cnt == '0) && (idle_q == CYC_W'(IDLE_LIMIT - 1)));
  end

  // Run-control registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q <= '0;
      idle_q  <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      idle_q  <= idle_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

  trace_fifo_mw #(
    .EW    (ENTRY_W),
    .CH    (CH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_cnt_i   (wr_cnt),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .level_o    (level_o),
    .space_o    (space)
  );

  assign drop_cnt_o = drop_q;
  assign cycle_o    = cycle_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: a vector table for single/dual capture,
// pop and idle stop, plus sequences for overflow, run-length stop with pointer
// wrap, and asynchronous reset mid-run.
module tb_cpu_trace_monitor;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int CH      = 2;
  localparam int DEPTH   = 16;
  localparam int CYC_W   = 16;
  localparam int ENTRY_W = CYC_W + 1 + ADDR_W + DATA_W;
  localparam int NVEC    = 21;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b0;
  logic [CH-1:0]          ev_we_i = '0;
  logic [CH*ADDR_W-1:0]   ev_addr_i = '0;
  logic [CH*DATA_W-1:0]   ev_data_i = '0;
  logic                   rd_en_i = 1'b0;
  logic                   rd_valid_o;
  logic [ENTRY_W-1:0]     rd_data_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [15:0]            drop_cnt_o;
  logic [CYC_W-1:0]       cycle_o;
  logic                   done_o;

  int checks   = 0;
  int failures = 0;

  cpu_trace_monitor dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ev_we_i    (ev_we_i),
    .ev_addr_i  (ev_addr_i),
    .ev_data_i  (ev_data_i),
    .rd_en_i    (rd_en_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o),
    .cycle_o    (cycle_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]          we;
    logic [7:0]          a0;
    logic [31:0]         d0;
    logic [7:0]          a1;
    logic [31:0]         d1;
    logic                rd;
    int                  lvl;
    logic [ENTRY_W-1:0]  head;
    int                  drop;
    logic                done;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic logic [ENTRY_W-1:0] mk(input int cyc, input int ch,
                                            input logic [7:0] a, input logic [31:0] d);
    return {16'(cyc), 1'(ch), a, d};
  endfunction

  function automatic vec_t v(input logic [1:0] we, input logic [7:0] a0, input logic [31:0] d0,
                             input logic [7:0] a1, input logic [31:0] d1, input logic rd,
                             input int lvl, input logic [ENTRY_W-1:0] head, input logic done);
    vec_t r;
    r.we = we; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.rd = rd;
    r.lvl = lvl; r.head = head; r.drop = 0; r.done = done;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] we, input logic [7:0] a0, input logic [31:0] d0,
                       input logic [7:0] a1, input logic [31:0] d1, input logic rd);
    ev_we_i   = we;
    ev_addr_i = {a1, a0};
    ev_data_i = {d1, d0};
    rd_en_i   = rd;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  logic [ENTRY_W-1:0] q [$];
  int nread;

  initial begin
    // Cycle numbers below are the cycle_o value during which inputs are held.
    tbl[0]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b0, 0, '0, 1'b0);
    tbl[1]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b0, 0, '0, 1'b0);
    tbl[2]  = v(2'b11, 8'h4, 32'hA,  8'h8,  32'hB,    1'b0, 2, mk(2, 0, 8'h4, 32'hA), 1'b0);
    tbl[3]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b1, 1, mk(2, 1, 8'h8, 32'hB), 1'b0);
    tbl[4]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b1, 0, '0, 1'b0);
    tbl[5]  = v(2'b01, 8'h3, 32'h11, 8'h0,  32'h0,    1'b0, 1, mk(5, 0, 8'h3, 32'h11), 1'b0);
    tbl[6]  = v(2'b10, 8'h0, 32'h0,  8'h20, 32'hDEAD, 1'b1, 1, mk(6, 1, 8'h20, 32'hDEAD), 1'b0);
    tbl[7]  = v(2'b11, 8'h5, 32'h55, 8'h6,  32'h66,   1'b1, 2, mk(7, 0, 8'h5, 32'h55), 1'b0);
    tbl[8]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b1, 1, mk(7, 1, 8'h6, 32'h66), 1'b0);
    tbl[9]  = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b1, 0, '0, 1'b0);
    tbl[10] = v(2'b01, 8'h1, 32'h1,  8'h0,  32'h0,    1'b1, 1, mk(10, 0, 8'h1, 32'h1), 1'b0);
    for (int i = 11; i <= 17; i++)
      tbl[i] = v(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 1, mk(10, 0, 8'h1, 32'h1), 1'b0);
    tbl[18] = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b0, 1, mk(10, 0, 8'h1, 32'h1), 1'b1);
    tbl[19] = v(2'b11, 8'h9, 32'h99, 8'hA,  32'hAA,   1'b0, 1, mk(10, 0, 8'h1, 32'h1), 1'b1);
    tbl[20] = v(2'b00, 8'h0, 32'h0,  8'h0,  32'h0,    1'b1, 0, '0, 1'b1);

    // Reset values while reset is held.
    #2;
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_cycle", 64'(cycle_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);

    // Table: capture, multi-push order, show-ahead pop, idle stop and post-done ignore.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].rd);
      tick();
      chk($sformatf("v%0d_level", i), 64'(level_o), 64'(tbl[i].lvl));
      chk($sformatf("v%0d_valid", i), 64'(rd_valid_o), 64'(tbl[i].lvl != 0));
      if (tbl[i].lvl != 0) chk($sformatf("v%0d_head", i), 64'(rd_data_o), 64'(tbl[i].head));
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt_o), 64'(tbl[i].drop));
      chk($sformatf("v%0d_done", i), 64'(done_o), 64'(tbl[i].done));
      chk($sformatf("v%0d_cycle", i), 64'(cycle_o), 64'(i + 1));
    end

    // Overflow: fill to 15, a dual event drops, a single event fills to 16,
    // then a single event with a pop still drops because space is judged pre-pop.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 8'(i + 1), 32'(i), 8'(i + 8'h40), 32'(i), 1'b0);
      tick();
    end
    drive(2'b01, 8'h7F, 32'h7F, 8'h0, 32'h0, 1'b0);
    tick();
    chk("ovf_fill15", 64'(level_o), 64'd15);
    drive(2'b11, 8'h31, 32'h31, 8'h32, 32'h32, 1'b0);
    tick();
    chk("ovf_dual_level", 64'(level_o), 64'd15);
    chk("ovf_dual_drop", 64'(drop_cnt_o), 64'd2);
    drive(2'b01, 8'h33, 32'h33, 8'h0, 32'h0, 1'b0);
    tick();
    chk("ovf_single_level", 64'(level_o), 64'd16);
    chk("ovf_single_drop", 64'(drop_cnt_o), 64'd2);
    drive(2'b10, 8'h0, 32'h0, 8'h34, 32'h34, 1'b1);
    tick();
    chk("ovf_fullpop_level", 64'(level_o), 64'd15);
    chk("ovf_fullpop_drop", 64'(drop_cnt_o), 64'd3);
    chk("ovf_head", 64'(rd_data_o), 64'(mk(0, 1, 8'h40, 32'h0)));
    drive(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0);

    // Run-length stop with continuous popping; 20 entries wrap the 16-deep pointers.
    do_reset();
    q.delete();
    nread = 0;
    for (int c = 0; c <= 101; c++) begin
      if ((c % 5 == 0) && (c < 100)) drive(2'b01, 8'(c + 1), 32'h1000 + 32'(c), 8'h0, 32'h0, 1'b1);
      else                          drive(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1);
      if (rd_valid_o) begin
        if (q.size() == 0) begin
          chk("rl_unexpected_entry", 64'(rd_data_o), 64'd0);
        end else begin
          chk($sformatf("rl_entry%0d", nread), 64'(rd_data_o), 64'(q[0]));
          void'(q.pop_front());
          nread++;
        end
      end
      tick();
      if ((c % 5 == 0) && (c < 100)) q.push_back(mk(c, 0, 8'(c + 1), 32'h1000 + 32'(c)));
      if (c == 98) chk("rl_done_early", 64'(done_o), 64'd0);
      if (c == 99) begin
        chk("rl_done", 64'(done_o), 64'd1);
        chk("rl_cycle", 64'(cycle_o), 64'd100);
      end
    end
    chk("rl_nread", 64'(nread), 64'd20);
    chk("rl_level", 64'(level_o), 64'd0);
    chk("rl_drop", 64'(drop_cnt_o), 64'd0);

    // Asynchronous reset mid-cycle with 5 entries queued.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 8'(i + 1), 32'(i), 8'h0, 32'h0, 1'b0);
      tick();
    end
    drive(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0);
    chk("mr_level_pre", 64'(level_o), 64'd5);
    #3;
    rst_i = 1'b0;
    #1;
    chk("mr_level", 64'(level_o), 64'd0);
    chk("mr_valid", 64'(rd_valid_o), 64'd0);
    chk("mr_cycle", 64'(cycle_o), 64'd0);
    chk("mr_done", 64'(done_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    chk("mr_cycle_release", 64'(cycle_o), 64'd0);

    // Channel-0 write to address 0.
    drive(2'b01, 8'h0, 32'h77, 8'h0, 32'h0, 1'b0);
    tick();
    drive(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0);
    chk("r0_cycle", 64'(cycle_o), 64'd1);
`ifdef TRACE_R0_FILTER_EN
    chk("r0_filtered_level", 64'(level_o), 64'd0);
    chk("r0_filtered_drop", 64'(drop_cnt_o), 64'd0);
`else
    chk("r0_level", 64'(level_o), 64'd1);
    chk("r0_head", 64'(rd_data_o), 64'(mk(0, 0, 8'h0, 32'h77)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable, parametrised writeback/store trace monitor attached beside the pipelined CPU. It captures register-file writes and data-memory writes from up to CH channels into a timestamped trace FIFO. It also provides the run-length and idle stop decision in hardware, so benches and FPGA builds read a compact event stream instead of polling the full register and memory state every cycle.

## Interface
- DATA_W, 32, write-data width per channel
- ADDR_W, 8, write-address width (register index zero-extended)
- CH, 2, number of event channels (ch0 = RF writeback, ch1 = DM store by convention)
- DEPTH, 16, trace FIFO entries, power of two, ≥ CH
- CYC_W, 16, timestamp/cycle-counter width
- MAX_CYCLES, 100, run length before forced stop
- IDLE_LIMIT, 8, consecutive event-free cycles before stop
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- ev_we_i  in  CH  per-channel write strobe
- ev_addr_i  in  CH*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
- ev_data_i  in  CH*DATA_W  per-channel data, same packing
- rd_en_i  in  1  pop request
- rd_valid_o  out  1  FIFO non-empty
- rd_data_o  out  ENTRY_W  head entry {cycle, ch, addr, data}; ENTRY_W = CYC_W+CH_W+ADDR_W+DATA_W, CH_W = max(1, clog2(CH))
- level_o  out  clog2(DEPTH)+1  occupancy
- drop_cnt_o  out  16  events lost to a full FIFO, saturating
- cycle_o  out  CYC_W  cycles since reset release, saturating
- done_o  out  1  sticky stop flag

## Operation
- Cycle counter increments every clock after reset and saturates at all-ones.
- Capture is enabled while done_o = 0. Valid events in a cycle are those channels with ev_we_i[k] = 1, after filtering.
- Multi-push: all n valid events in a cycle are written in ascending channel order at consecutive slots, stamped with the current cycle_o, provided free space (DEPTH − level before any pop this cycle) ≥ n.
- If space < n, none are written and drop_cnt_o += n, saturating at 0xFFFF. The push is all-or-nothing per cycle.
- Pop: when rd_en_i && rd_valid_o, the head advances. rd_en_i while empty is ignored. Popping remains allowed after done.
- Idle counter: resets on any cycle with n > 0 and otherwise increments, saturating.
- done_o sets when cycle_o == MAX_CYCLES−1 or idle count == IDLE_LIMIT−1 (with n = 0) at a clock edge. Once set it stays set until reset, and capture stops.
- Events on the cycle done_o rises are still captured. Events from the following cycle onward are ignored and are not counted as drops.

## Timing
- Reset values: rd_valid_o 0, rd_data_o undefined (memory not cleared), level_o 0, drop_cnt_o 0, cycle_o 0, done_o 0. Pointers and counters are cleared asynchronously.
- Push latency is 1: an event at edge t is visible on rd_data_o/rd_valid_o after edge t when the FIFO was empty.
- rd_data_o is show-ahead: it reflects the head combinationally from registered pointers.
- Simultaneous push and pop: both take effect. level_o changes by n−1. Space is judged pre-pop, so a full FIFO with a pop still drops incoming events.
- Pointers use DEPTH entries plus one wrap bit. Full means level == DEPTH. Wrap-around is seamless.
- Reset asserted mid-run returns all state to reset values immediately. The first post-release cycle has cycle_o = 0.

## Configuration
- TRACE_R0_FILTER_EN: when defined, channel 0 events with addr == 0 (writes to $zero) are discarded before counting. They are not traced, not dropped, and still count as idle.
- Undefined: every strobed event is traced.

## Structure
- A shared package cpu_trace_pkg holds the entry field widths, the CH_W computation, the channel index constants (CH_RF = 0, CH_DM = 1), and the drop-counter width.
- One sub-module, trace_fifo_mw: the multi-write, single-read FIFO with a write-count input and a space output. Timestamping, filtering, and stop logic live in the top level.

## Test plan
- Single RF write: ch0 addr 3 data 0x11 at cycle 5 -> entry {5, 0, 3, 0x11}, level_o 1, next edge.
- Dual event same cycle: ch0 (4, 0xA), ch1 (8, 0xB) at cycle 2 -> two entries in ch0, ch1 order, both stamped 2, level_o 2.
- Overflow: fill to 15 of 16, then issue a 2-event cycle -> no write, level_o stays 15, drop_cnt_o 2. A 1-event cycle then succeeds with level_o 16.
- Idle stop: IDLE_LIMIT 8, last event at cycle 10 -> done_o high after cycle 18. Later strobes are ignored and drop_cnt_o is unchanged.
- Run-length stop and wrap: 20 single events across MAX_CYCLES 100, popping continuously -> entries read in order through pointer wrap, and done_o high after cycle 99.
- Reset mid-run with 5 entries queued -> level_o 0, rd_valid_o 0, cycle_o 0, done_o 0. With TRACE_R0_FILTER_EN defined, a ch0 addr 0 write produces no entry.
